// File: rtl/snake_target_ctrl_pkg.sv
// Shared definitions for the Snake food-target controller:
// default grid geometry, FSM state encoding and the LFSR step function.
package snake_target_ctrl_pkg;

    localparam int unsigned DEF_X_WIDTH = 8;
    localparam int unsigned DEF_Y_WIDTH = 7;
    localparam int unsigned DEF_X_MAX   = 159;
    localparam int unsigned DEF_Y_MAX   = 119;

    typedef enum logic [1:0] {
        ST_PLACE = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCORE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Fibonacci form, taps 16,14,13,11: shift left, feedback into bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/snake_target_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the target position source.
// Ports: CLK, RESET (async, active-high, loads SEED), LFSR_OUT current state.
module snake_lfsr16
    import snake_target_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [15:0] LFSR_OUT
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d   = lfsr16_next(lfsr_q);
    assign LFSR_OUT = lfsr_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/snake_target_ctrl.sv
// Places the Snake food target, detects head hits, holds SCORE_EN for one
// score-counter strobe period per hit, counts hits and flags the win.
// Ports: CLK, RESET (async, active-high), GAME_ACTIVE, HEAD_VALID, HEAD_X/Y in;
// TARGET_X/Y, TARGET_VALID, SCORE_EN, HIT_COUNT, WIN out (all registered).
module snake_target_ctrl
    import snake_target_ctrl_pkg::*;
#(
    parameter int unsigned X_WIDTH           = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH           = DEF_Y_WIDTH,
    parameter int unsigned X_MAX             = DEF_X_MAX,
    parameter int unsigned Y_MAX             = DEF_Y_MAX,
    parameter int unsigned SCORE_HOLD_CYCLES = 100000,
    parameter int unsigned WIN_SCORE         = 10,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               GAME_ACTIVE,
    input  logic               HEAD_VALID,
    input  logic [X_WIDTH-1:0] HEAD_X,
    input  logic [Y_WIDTH-1:0] HEAD_Y,
    output logic [X_WIDTH-1:0] TARGET_X,
    output logic [Y_WIDTH-1:0] TARGET_Y,
    output logic               TARGET_VALID,
    output logic               SCORE_EN,
    output logic [7:0]         HIT_COUNT,
    output logic               WIN
);

    localparam int unsigned CNT_W =
        (SCORE_HOLD_CYCLES > 1) ? $clog2(SCORE_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_HOLD_CYCLES - 1);
    localparam logic [7:0]       WIN_CNT  = 8'(WIN_SCORE);
    localparam logic [X_WIDTH-1:0] XLIM   = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] YLIM   = Y_WIDTH'(Y_MAX);

    logic [15:0] lfsr;

    snake_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RESET   (RESET),
        .LFSR_OUT(lfsr)
    );

    logic [X_WIDTH-1:0] cand_x;
    logic [Y_WIDTH-1:0] cand_y;
    logic               unused_lfsr_bits;
    logic               accept;
    logic               hit;

    assign cand_x = lfsr[X_WIDTH-1:0];
    assign cand_y = lfsr[X_WIDTH+Y_WIDTH-1:X_WIDTH];
    assign unused_lfsr_bits = ^lfsr[15:X_WIDTH+Y_WIDTH];

    state_e             state_q, state_d;
    logic [X_WIDTH-1:0] tx_q, tx_d;
    logic [Y_WIDTH-1:0] ty_q, ty_d;
    logic               tvalid_q, tvalid_d;
    logic               score_en_q, score_en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hits_q, hits_d;
    logic               win_q, win_d;
    logic [7:0]         hits_inc;

    // A candidate never lands on the head's current cell, whether or
    // not HEAD_VALID is pulsing this cycle.
    assign accept = (cand_x <= XLIM) && (cand_y <= YLIM) &&
                    !((cand_x == HEAD_X) && (cand_y == HEAD_Y));

    assign hit = GAME_ACTIVE && HEAD_VALID &&
                 (HEAD_X == tx_q) && (HEAD_Y == ty_q);

    assign hits_inc = (hits_q == WIN_CNT) ? hits_q : hits_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        tvalid_d   = tvalid_q;
        score_en_d = score_en_q;
        cnt_d      = cnt_q;
        hits_d     = hits_q;
        win_d      = win_q;

        unique case (state_q)
            ST_PLACE: begin
                if (accept) begin
                    tx_d     = cand_x;
                    ty_d     = cand_y;
                    tvalid_d = 1'b1;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hit) begin
                    tvalid_d   = 1'b0;
                    score_en_d = 1'b1;
                    cnt_d      = '0;
                    hits_d     = hits_inc;
                    if (hits_inc == WIN_CNT) begin
                        win_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCORE;
                    end
                end
            end
            ST_SCORE: begin
                if (cnt_q == CNT_LAST) begin
                    score_en_d = 1'b0;
                    state_d    = ST_PLACE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Finish the last hit's pulse, then idle until reset.
                if (score_en_q) begin
                    if (cnt_q == CNT_LAST) begin
                        score_en_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_PLACE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_PLACE;
            tx_q       <= '0;
            ty_q       <= '0;
            tvalid_q   <= 1'b0;
            score_en_q <= 1'b0;
            cnt_q      <= '0;
            hits_q     <= '0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            tvalid_q   <= tvalid_d;
            score_en_q <= score_en_d;
            cnt_q      <= cnt_d;
            hits_q     <= hits_d;
            win_q      <= win_d;
        end
    end

    assign TARGET_X     = tx_q;
    assign TARGET_Y     = ty_q;
    assign TARGET_VALID = tvalid_q;
    assign SCORE_EN     = score_en_q;
    assign HIT_COUNT    = hits_q;
    assign WIN          = win_q;

endmodule
